// File: rtl/elm_pkg.sv
// Shared arithmetic helpers and activation selectors for the ELM neuron datapath.
// All helpers work on 64-bit signed containers; the width argument selects the clamp range.
package elm_pkg;

  localparam int ACT_RELU   = 0;
  localparam int ACT_LINEAR = 1;

  function automatic logic signed [64:0] sat_clamp(input logic signed [64:0] v, input int w);
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (v > hi) begin
      sat_clamp = hi;
    end else if (v < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = v;
    end
  endfunction

  // Saturating signed add; operands must already lie inside the w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [64:0] s;
    logic signed [64:0] c;
    s = {a[63], a} + {b[63], b};
    c = sat_clamp(s, w);
    sat_add = c[63:0];
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] a, input int w);
    logic signed [64:0] s;
    logic signed [64:0] c;
    s = {a[63], a};
    c = sat_clamp(s, w);
    sat_narrow = c[63:0];
  endfunction

endpackage

// File: rtl/elm_activation.sv
// Combinational output stage: bias add, rescale to dataWidth, saturate and activate.
module elm_activation
  import elm_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int fracBits  = 12,
  parameter int actType   = 0
) (
  input  logic [2*dataWidth-1:0] sum,
  input  logic [dataWidth-1:0]   bias,
  output logic [dataWidth-1:0]   y
);

  localparam int PW = 2 * dataWidth;

  logic signed [PW-1:0]        bias_ext;
  logic signed [63:0]          biased;
  logic signed [63:0]          shifted;
  logic signed [63:0]          narrowed;
  logic        [dataWidth-1:0] nar;

  // Bias is aligned to the product's fixed point before the add.
  always_comb begin
    bias_ext = PW'($signed(bias)) <<< fracBits;
    biased   = sat_add(64'($signed(sum)), 64'(bias_ext), PW);
    shifted  = biased >>> fracBits;
    narrowed = sat_narrow(shifted, dataWidth);
    nar      = narrowed[dataWidth-1:0];
    case (actType)
      ACT_RELU:   y = nar[dataWidth-1] ? '0 : nar;
      ACT_LINEAR: y = nar;
      default:    y = nar;
    endcase
  end

endmodule

// File: rtl/elm_neuron_mac.sv
// ELM hidden-layer neuron: weight fetch, multiply, saturating accumulate over one
// input vector, then bias + activation into a registered output word.
module elm_neuron_mac
  import elm_pkg::*;
#(
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 12,
  parameter int actType      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [dataWidth-1:0]  myinput,
  input  logic                  myinputValid,
  output logic                  ren,
  output logic [addressWidth:0] raddr,
  input  logic [dataWidth-1:0]  wout,
  input  logic [dataWidth-1:0]  bias,
  output logic [dataWidth-1:0]  out,
  output logic                  outvalid
);

  localparam int PW = 2 * dataWidth;
  localparam int AW = addressWidth + 1;
  localparam logic [addressWidth:0] LAST = AW'(numWeight - 1);
  localparam logic [addressWidth:0] ONE  = AW'(1);

  logic [addressWidth:0]       wcnt;
  logic [addressWidth:0]       pcnt;
  logic signed [dataWidth-1:0] in_r;
  logic                        valid1_r;
  logic signed [PW-1:0]        mul_r;
  logic                        valid2_r;
  logic signed [PW-1:0]        acc_r;
  logic signed [PW-1:0]        sum_r;
  logic                        valid3_r;
  logic signed [PW-1:0]        acc_next_s;
  logic signed [63:0]          acc_wide_s;
  logic [dataWidth-1:0]        act_s;

  assign ren   = myinputValid;
  assign raddr = wcnt;

  // Saturating next value of the running sum.
  always_comb begin
    acc_wide_s = sat_add(64'(acc_r), 64'(mul_r), PW);
    acc_next_s = acc_wide_s[PW-1:0];
  end

  elm_activation #(
    .dataWidth(dataWidth),
    .fracBits (fracBits),
    .actType  (actType)
  ) u_act (
    .sum (sum_r),
    .bias(bias),
    .y   (act_s)
  );

  // Pipeline: each stage advances only when its own valid flag is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      pcnt     <= '0;
      in_r     <= '0;
      valid1_r <= 1'b0;
      mul_r    <= '0;
      valid2_r <= 1'b0;
      acc_r    <= '0;
      sum_r    <= '0;
      valid3_r <= 1'b0;
      out      <= '0;
      outvalid <= 1'b0;
    end else begin
      if (myinputValid) begin
        wcnt <= (wcnt == LAST) ? '0 : wcnt + ONE;
        in_r <= $signed(myinput);
      end
      valid1_r <= myinputValid;

      if (valid1_r) begin
        mul_r <= PW'(in_r) * PW'($signed(wout));
      end
      valid2_r <= valid1_r;

      // Last term hands the sum off and clears acc so the next vector starts at once.
      valid3_r <= 1'b0;
      if (valid2_r) begin
        if (pcnt == LAST) begin
          sum_r    <= acc_next_s;
          acc_r    <= '0;
          pcnt     <= '0;
          valid3_r <= 1'b1;
        end else begin
          acc_r <= acc_next_s;
          pcnt  <= pcnt + ONE;
        end
      end

      outvalid <= valid3_r;
      if (valid3_r) begin
        out <= act_s;
      end
    end
  end

endmodule
